// File: rtl/pmbist_pkg.sv
// -----------------------------------------------------------------------------
// pmbist_pkg
// Shared definitions for the memory-BIST response path.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   CNT_W / CNT_MAX         : width and saturation value of the fail counter
//   fail_rec_t              : fail-log record layout, {addr, syndrome} with the
//                             address in the upper bits
//   rec_width()             : record width for non-default parameterisations
// -----------------------------------------------------------------------------
package pmbist_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] syn;
  } fail_rec_t;

  function automatic int rec_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/response_analyzer_fail_fifo.sv
// -----------------------------------------------------------------------------
// fail_fifo
// Synchronous first-word-fall-through FIFO holding fail records.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr_in          : synchronous flush (empties the FIFO)
//   push_in, din_in : write request and record
//   pop_in          : remove head entry (ignored when empty)
//   vld_out         : FIFO non-empty; dout_out shows the head entry
//   drop_out        : a push was refused because the FIFO was full
// A push and a pop in the same cycle on a full FIFO both succeed.
// -----------------------------------------------------------------------------
module fail_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] dout_out,
  output logic             drop_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_pop_ok  = pop_in && !w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_push_ok = push_in && (!w_full || w_pop_ok);
  assign drop_out  = push_in && !w_push_ok;

  always_ff @(posedge clk) begin
    if (rst || clr_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din_in;
  end

  // Head is read asynchronously so the oldest record is visible without a pop.
  assign vld_out  = !w_empty;
  assign dout_out = r_mem[r_rd_ptr];

endmodule

// File: rtl/response_analyzer.sv
// -----------------------------------------------------------------------------
// response_analyzer
// Compares memory read data against the expected pattern, keeps a sticky fail
// flag, a saturating mismatch counter and a done/pass status, and optionally
// logs {address, syndrome} of each mismatch.
// Build option: define RESPONSE_ANALYZER_FAIL_LOG_EN to include the fail log;
// otherwise the log outputs are tied low and pop_in is ignored.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rd_in           : read strobe; exp_in / addr_in are sampled with it
//   data_in         : memory read data, valid RD_LAT cycles after rd_in
//   end_in          : pulse with/after the last read
//   clr_in          : synchronous clear of all results and in-flight reads
//   pop_in          : remove head of fail log
//   fail_out, fail_cnt_out, done_out, pass_out : result status
//   log_vld_out, log_addr_out, log_syn_out     : fail-log head (FWFT)
//   ovfl_out        : sticky, a fail record was dropped on a full log
// -----------------------------------------------------------------------------
module response_analyzer
  import pmbist_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_in,
  input  logic [DATA_W-1:0] exp_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              end_in,
  input  logic              clr_in,
  input  logic              pop_in,
  output logic              fail_out,
  output logic [CNT_W-1:0]  fail_cnt_out,
  output logic              done_out,
  output logic              pass_out,
  output logic              log_vld_out,
  output logic [ADDR_W-1:0] log_addr_out,
  output logic [DATA_W-1:0] log_syn_out,
  output logic              ovfl_out
);

  // Stage i holds the read issued i+1 cycles ago; the last stage lines up
  // with data_in.
  logic              r_tag_pipe  [RD_LAT];
  logic              r_end_pipe  [RD_LAT];
  logic [DATA_W-1:0] r_exp_pipe  [RD_LAT];
  logic [ADDR_W-1:0] r_addr_pipe [RD_LAT];

  logic              r_fail;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  logic              w_flush;
  logic [DATA_W-1:0] w_syn;
  logic              w_mismatch;

  // Reset and clear both drop every in-flight read, including one issued now.
  assign w_flush = rst || clr_in;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_pipe[i] <= 1'b0;
        r_end_pipe[i] <= 1'b0;
      end
    end else begin
      r_tag_pipe[0] <= rd_in;
      r_end_pipe[0] <= end_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
        r_end_pipe[i] <= r_end_pipe[i-1];
      end
    end
  end

  // Payload stages need no reset: they are only consumed when tagged.
  always_ff @(posedge clk) begin
    r_exp_pipe[0]  <= exp_in;
    r_addr_pipe[0] <= addr_in;
    for (int i = 1; i < RD_LAT; i++) begin
      r_exp_pipe[i]  <= r_exp_pipe[i-1];
      r_addr_pipe[i] <= r_addr_pipe[i-1];
    end
  end

  assign w_syn      = data_in ^ r_exp_pipe[RD_LAT-1];
  assign w_mismatch = r_tag_pipe[RD_LAT-1] && (w_syn != '0);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_fail <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
      if (r_end_pipe[RD_LAT-1]) r_done <= 1'b1;
    end
  end

  assign fail_out     = r_fail;
  assign fail_cnt_out = r_cnt;
  assign done_out     = r_done;
  assign pass_out     = r_done && !r_fail;

`ifdef RESPONSE_ANALYZER_FAIL_LOG_EN
  localparam int REC_W = rec_width(ADDR_W, DATA_W);

  logic             w_log_push;
  logic             w_log_drop;
  logic [REC_W-1:0] w_log_head;
  logic             r_ovfl;

  assign w_log_push = w_mismatch && !clr_in;

  fail_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fail_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr_in   (clr_in),
    .push_in  (w_log_push),
    .pop_in   (pop_in),
    .din_in   ({r_addr_pipe[RD_LAT-1], w_syn}),
    .vld_out  (log_vld_out),
    .dout_out (w_log_head),
    .drop_out (w_log_drop)
  );

  always_ff @(posedge clk) begin
    if (w_flush)         r_ovfl <= 1'b0;
    else if (w_log_drop) r_ovfl <= 1'b1;
  end

  assign log_addr_out = w_log_head[REC_W-1 -: ADDR_W];
  assign log_syn_out  = w_log_head[DATA_W-1:0];
  assign ovfl_out     = r_ovfl;
`else
  logic w_unused_log;
  assign w_unused_log = ^{pop_in, r_addr_pipe[RD_LAT-1]};

  assign log_vld_out  = 1'b0;
  assign log_addr_out = '0;
  assign log_syn_out  = '0;
  assign ovfl_out     = 1'b0;
`endif

endmodule

// File: tb/tb_response_analyzer.sv
// -----------------------------------------------------------------------------
// tb_response_analyzer
// Drives two analyzers (read latency 1 and 3) from one stimulus stream with a
// behavioural memory, and checks them against an event-history reference.
// -----------------------------------------------------------------------------
module tb_response_analyzer;

`ifdef RESPONSE_ANALYZER_FAIL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rd, endp, clr, pop;
  logic [7:0] expv, addr;
  logic [7:0] data1, data3;

  logic [1:0]      o_fail, o_done, o_pass, o_lv, o_ov;
  logic [1:0][7:0] o_cnt, o_la, o_ls;

  // Behavioural memory: data for a read at cycle t appears at cycle t+latency.
  logic [7:0] mem [256];
  logic [7:0] dpipe [3];
  always @(posedge clk) begin
    dpipe[0] <= mem[addr];
    dpipe[1] <= dpipe[0];
    dpipe[2] <= dpipe[1];
  end
  assign data1 = dpipe[0];
  assign data3 = dpipe[2];

  response_analyzer #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .FIFO_DEPTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .rd_in(rd), .exp_in(expv), .addr_in(addr), .data_in(data1),
    .end_in(endp), .clr_in(clr), .pop_in(pop),
    .fail_out(o_fail[0]), .fail_cnt_out(o_cnt[0]), .done_out(o_done[0]), .pass_out(o_pass[0]),
    .log_vld_out(o_lv[0]), .log_addr_out(o_la[0]), .log_syn_out(o_ls[0]), .ovfl_out(o_ov[0]));

  response_analyzer #(.DATA_W(8), .ADDR_W(8), .RD_LAT(3), .FIFO_DEPTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .rd_in(rd), .exp_in(expv), .addr_in(addr), .data_in(data3),
    .end_in(endp), .clr_in(clr), .pop_in(pop),
    .fail_out(o_fail[1]), .fail_cnt_out(o_cnt[1]), .done_out(o_done[1]), .pass_out(o_pass[1]),
    .log_vld_out(o_lv[1]), .log_addr_out(o_la[1]), .log_syn_out(o_ls[1]), .ovfl_out(o_ov[1]));

  // Reference model: per-edge event history plus one log queue per instance.
  bit         mmh  [4096];
  bit         endh [4096];
  bit         clrh [4096];
  logic [7:0] addrh[4096];
  logic [7:0] synh [4096];
  int         cyc = 0;
  int         last_clr = -1;
  logic [15:0] mq [2][$];
  bit          movf [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Mismatches issued after the last clear whose result has been registered.
  function automatic int exp_cnt(input int l);
    int n = 0;
    for (int t = last_clr + 1; t + l <= cyc - 1; t++) if (mmh[t]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic bit exp_done(input int l);
    bit r = 1'b0;
    for (int t = last_clr + 1; t + l <= cyc - 1; t++) if (endh[t]) r = 1'b1;
    return r;
  endfunction

  // One clock edge: record the sampled inputs, advance the log model.
  task automatic tick();
    int  t;
    bit  push;
    bit  pop_ok;
    @(posedge clk);
    mmh[cyc]   = rd && !rst && (expv != mem[addr]);
    synh[cyc]  = expv ^ mem[addr];
    addrh[cyc] = addr;
    endh[cyc]  = endp && !rst;
    clrh[cyc]  = clr || rst;
    for (int d = 0; d < 2; d++) begin
      if (clrh[cyc]) begin
        mq[d].delete();
        movf[d] = 1'b0;
      end else begin
        t      = cyc - lat(d);
        push   = (t >= 0) && (t > last_clr) && mmh[t];
        pop_ok = pop && (mq[d].size() > 0);
        if (pop_ok) void'(mq[d].pop_front());
        if (push) begin
          if (mq[d].size() < 8) mq[d].push_back({addrh[t], synh[t]});
          else movf[d] = 1'b1;
        end
      end
    end
    if (clrh[cyc]) last_clr = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_clear();
    rd = 1'b0; endp = 1'b0; pop = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; rd = 1'b1; expv = 8'h01; addr = 8'h00; endp = 1'b1; clr = 1'b0; pop = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_fail[d], o_cnt[d], o_done[d], o_pass[d], o_lv[d], o_ov[d]} !== 13'h0) begin
        miscompares++;
        $display("FAIL reset_state d%0d: got fail=%b cnt=%0d done=%b pass=%b lv=%b ov=%b want all 0",
                 d, o_fail[d], o_cnt[d], o_done[d], o_pass[d], o_lv[d], o_ov[d]);
      end
    end
    rst = 1'b0; rd = 1'b0; endp = 1'b0; pop = 1'b0;
    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_fail[d], o_cnt[d], o_done[d]} !== 10'h0) begin
        miscompares++;
        $display("FAIL reads_in_reset d%0d: got fail=%b cnt=%0d done=%b want 0 0 0",
                 d, o_fail[d], o_cnt[d], o_done[d]);
      end
    end
  endtask

  task automatic test_all_match();
    for (int i = 0; i < 16; i++) mem[i] = 8'h55;
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; addr = 8'(i); expv = 8'h55;
      tick();
    end
    rd = 1'b0; endp = 1'b1;
    tick();
    endp = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_fail[d], o_cnt[d], o_done[d], o_pass[d]} !==
            {1'b0, 8'h00, exp_done(lat(d)), exp_done(lat(d))}) begin
          miscompares++;
          $display("FAIL all_match d%0d step%0d: got fail=%b cnt=%0d done=%b pass=%b want 0 0 %b %b",
                   d, j, o_fail[d], o_cnt[d], o_done[d], o_pass[d], exp_done(lat(d)), exp_done(lat(d)));
        end
      end
      tick();
    end
    vectors++;
    if ({o_done[0], o_pass[0]} !== 2'b11) begin
      miscompares++;
      $display("FAIL all_match_final: got done=%b pass=%b want 1 1", o_done[0], o_pass[0]);
    end
  endtask

  task automatic test_single_fault();
    mem[8'h12] = 8'hAB;
    rd = 1'b1; addr = 8'h12; expv = 8'hAA;
    tick();
    rd = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_fail[d], o_cnt[d]} !== {exp_cnt(lat(d)) > 0, 8'(exp_cnt(lat(d)))}) begin
          miscompares++;
          $display("FAIL single_fault_timing d%0d cyc+%0d: got fail=%b cnt=%0d want %b %0d",
                   d, j, o_fail[d], o_cnt[d], exp_cnt(lat(d)) > 0, exp_cnt(lat(d)));
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_fail[d], o_cnt[d], o_lv[d], o_la[d], o_ls[d]} !==
          {1'b1, 8'd1, LOG_EN, LOG_EN ? 8'h12 : 8'h00, LOG_EN ? 8'h01 : 8'h00}) begin
        miscompares++;
        $display("FAIL single_fault_log d%0d: got fail=%b cnt=%0d lv=%b addr=%h syn=%h want 1 1 %b %h %h",
                 d, o_fail[d], o_cnt[d], o_lv[d], o_la[d], o_ls[d], LOG_EN,
                 LOG_EN ? 8'h12 : 8'h00, LOG_EN ? 8'h01 : 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 10; a++) mem[a] = 8'(a);
    for (int j = 0; j < 16; j++) begin
      rd   = (j < 10);
      addr = 8'(j);
      expv = (j == 3 || j == 7) ? (8'(j) ^ 8'h10) : 8'(j);
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (o_cnt[d] !== 8'(exp_cnt(lat(d)))) begin
          miscompares++;
          $display("FAIL back_to_back_cnt d%0d step%0d: got %0d want %0d",
                   d, j, o_cnt[d], exp_cnt(lat(d)));
        end
      end
    end
    rd = 1'b0;
    for (int e = 0; e < 3; e++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_lv[d], o_la[d]} !== {(e < 2) && LOG_EN,
                                    ((e < 2) && LOG_EN) ? ((e == 0) ? 8'h03 : 8'h07) : 8'h00}) begin
          miscompares++;
          $display("FAIL back_to_back_log d%0d entry%0d: got lv=%b addr=%h want lv=%b",
                   d, e, o_lv[d], o_la[d], (e < 2) && LOG_EN);
        end
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) mem[8'h20 + i] = 8'(i);
    for (int j = 0; j < 15; j++) begin
      rd = (j < 10); addr = 8'(8'h20 + j); expv = ~8'(j);
      tick();
    end
    rd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_cnt[d], o_ov[d]} !== {8'd10, LOG_EN}) begin
        miscompares++;
        $display("FAIL overflow_flag d%0d: got cnt=%0d ovfl=%b want 10 %b", d, o_cnt[d], o_ov[d], LOG_EN);
      end
    end
    for (int e = 0; e < 9; e++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_lv[d], o_la[d]} !== {(e < 8) && LOG_EN,
                                    ((e < 8) && LOG_EN) ? 8'(8'h20 + e) : 8'h00}) begin
          miscompares++;
          $display("FAIL overflow_kept d%0d entry%0d: got lv=%b addr=%h want lv=%b addr=%h", d, e,
                   o_lv[d], o_la[d], (e < 8) && LOG_EN, ((e < 8) && LOG_EN) ? 8'(8'h20 + e) : 8'h00);
        end
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    // Full log: a pop coinciding with the ninth push keeps eight records.
    do_clear();
    for (int j = 0; j < 14; j++) begin
      rd = (j < 9); addr = 8'(8'h20 + (j % 10)); expv = ~8'(j % 10); pop = (j == 9);
      tick();
    end
    rd = 1'b0; pop = 1'b0;
    for (int e = 0; e < 9; e++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_lv[d], o_ov[d]} !== {(e < 8) && LOG_EN, 1'b0} ||
            ((mq[d].size() > 0) && LOG_EN && {o_la[d], o_ls[d]} !== mq[d][0])) begin
          miscompares++;
          $display("FAIL full_push_pop d%0d entry%0d: got lv=%b ovfl=%b addr=%h want lv=%b ovfl=0",
                   d, e, o_lv[d], o_ov[d], o_la[d], (e < 8) && LOG_EN);
        end
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  task automatic test_clear_in_flight();
    mem[8'h40] = 8'h00;
    rd = 1'b1; addr = 8'h40; expv = 8'h01;
    tick();
    rd = 1'b0;
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_fail[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_precondition d%0d: got fail=%b want 1", d, o_fail[d]);
      end
    end
    rd = 1'b1; expv = 8'h02;
    tick();
    expv = 8'h04; clr = 1'b1;
    tick();
    rd = 1'b0; clr = 1'b0;
    for (int j = 0; j < 5; j++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({o_fail[d], o_cnt[d], o_done[d], o_pass[d], o_lv[d], o_ov[d]} !== 13'h0) begin
          miscompares++;
          $display("FAIL clear_in_flight d%0d step%0d: got fail=%b cnt=%0d lv=%b ovfl=%b want all 0",
                   d, j, o_fail[d], o_cnt[d], o_lv[d], o_ov[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    mem[8'h50] = 8'h00;
    for (int j = 0; j < 306; j++) begin
      rd = (j < 300); addr = 8'h50; expv = 8'h80;
      tick();
      if (j >= 250 && j < 262) begin
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (o_cnt[d] !== 8'(exp_cnt(lat(d)))) begin
            miscompares++;
            $display("FAIL saturate_edge d%0d step%0d: got %0d want %0d", d, j, o_cnt[d], exp_cnt(lat(d)));
          end
        end
      end
    end
    rd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_fail[d], o_cnt[d], o_ov[d]} !== {1'b1, 8'd255, LOG_EN}) begin
        miscompares++;
        $display("FAIL saturate d%0d: got fail=%b cnt=%0d ovfl=%b want 1 255 %b",
                 d, o_fail[d], o_cnt[d], o_ov[d], LOG_EN);
      end
    end
  endtask

  task automatic test_random();
    int  ec;
    bit  ed;
    logic [15:0] hd;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int j = 0; j < 400; j++) begin
      rd   = ($urandom_range(0, 3) != 0);
      addr = 8'($urandom);
      expv = ($urandom_range(0, 3) == 0) ? (mem[addr] ^ 8'($urandom_range(1, 255))) : mem[addr];
      endp = ($urandom_range(0, 39) == 0);
      clr  = ($urandom_range(0, 59) == 0);
      pop  = $urandom_range(0, 1) == 1;
      tick();
      for (int d = 0; d < 2; d++) begin
        ec = exp_cnt(lat(d));
        ed = exp_done(lat(d));
        vectors++;
        if ({o_fail[d], o_cnt[d], o_done[d], o_pass[d]} !== {ec > 0, 8'(ec), ed, ed && (ec == 0)}) begin
          miscompares++;
          $display("FAIL random_status d%0d step%0d: got fail=%b cnt=%0d done=%b pass=%b want %b %0d %b %b",
                   d, j, o_fail[d], o_cnt[d], o_done[d], o_pass[d], ec > 0, ec, ed, ed && (ec == 0));
        end
        vectors++;
        if ({o_lv[d], o_ov[d]} !== {LOG_EN && (mq[d].size() > 0), LOG_EN && movf[d]}) begin
          miscompares++;
          $display("FAIL random_logflags d%0d step%0d: got lv=%b ovfl=%b want %b %b", d, j, o_lv[d],
                   o_ov[d], LOG_EN && (mq[d].size() > 0), LOG_EN && movf[d]);
        end
        if (!LOG_EN || mq[d].size() > 0) begin
          hd = (mq[d].size() > 0) ? mq[d][0] : 16'h0000;
          hd = LOG_EN ? hd : 16'h0000;
          vectors++;
          if ({o_la[d], o_ls[d]} !== hd) begin
            miscompares++;
            $display("FAIL random_loghead d%0d step%0d: got %h want %h", d, j, {o_la[d], o_ls[d]}, hd);
          end
        end
      end
    end
    rd = 1'b0; endp = 1'b0; clr = 1'b0; pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_match();
    do_clear();
    test_single_fault();
    do_clear();
    test_back_to_back();
    do_clear();
    test_overflow();
    do_clear();
    test_clear_in_flight();
    do_clear();
    test_saturate();
    do_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/response_analyzer.md
RESPONSE_ANALYZER -- requirements
Module: response_analyzer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word and pattern width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have parameter RD_LAT, default 1 (legal 1..4), memory read latency in cycles.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8 (power of two, 2..16), fail-log entries.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_in  input  1  read strobe issued to memory this cycle.
REQ-008 SHALL have port exp_in  input  DATA_W  expected word from pattern_generator ptrn_out, sampled with rd_in.
REQ-009 SHALL have port addr_in  input  ADDR_W  read address, sampled with rd_in.
REQ-010 SHALL have port data_in  input  DATA_W  memory read data, valid RD_LAT cycles after rd_in.
REQ-011 SHALL have port end_in  input  1  one-cycle pulse marking last read issued.
REQ-012 SHALL have port clr_in  input  1  synchronous clear of all results.
REQ-013 SHALL have port pop_in  input  1  fail-log read request.
REQ-014 SHALL have ports fail_out 1, fail_cnt_out 8, done_out 1, pass_out 1, all outputs.
REQ-015 SHALL have ports log_vld_out 1, log_addr_out ADDR_W, log_syn_out DATA_W, ovfl_out 1, all outputs.

Function
REQ-016 SHALL delay exp_in/addr_in through an RD_LAT-deep shift pipeline tagged by rd_in, aligning them with data_in.
REQ-017 SHALL compute syndrome = data_in XOR aligned exp; mismatch = tagged AND syndrome nonzero.
REQ-018 SHALL register comparison results: fail_out/fail_cnt_out reflect a read issued at cycle t at cycle t+RD_LAT+1.
REQ-019 SHALL keep fail_out sticky high after first mismatch until rst or clr_in.
REQ-020 SHALL increment fail_cnt_out by one per mismatch, saturating at 255.
REQ-021 SHALL assert done_out at cycle t+RD_LAT+1 after end_in at t, holding until rst/clr_in; pass_out = done_out AND NOT fail_out.
REQ-022 SHALL treat back-to-back rd_in (every cycle) as independent compares, no bubbles.
REQ-023 SHALL give clr_in priority over a same-cycle mismatch and discard all in-flight pipeline tags.
REQ-024 SHALL ignore rd_in, end_in when rst is high.

Reset
REQ-025 SHALL on rst clear pipeline tags, fail_out, fail_cnt_out, done_out, pass_out, ovfl_out, log_vld_out, FIFO pointers to 0.
REQ-026 SHALL produce first valid compare no earlier than RD_LAT+1 cycles after rst deasserts.

Configuration
REQ-027 SHALL compile the fail log only when macro RESPONSE_ANALYZER_FAIL_LOG_EN is defined.
REQ-028 With macro: push {addr, syndrome} per mismatch; log_vld_out = FIFO non-empty, log_* show head entry (first-word-fall-through); pop_in with log_vld_out removes head next cycle.
REQ-029 With macro: push when full SHALL drop the record and set sticky ovfl_out; simultaneous push and pop when full SHALL succeed both; pop when empty ignored.
REQ-030 Without macro: log_vld_out, log_addr_out, log_syn_out, ovfl_out SHALL be tied 0; pop_in ignored.

Structure
REQ-031 SHALL place DATA_W/ADDR_W defaults and fail-record field layout in shared package pmbist_pkg.
REQ-032 SHALL implement the log as sub-module fail_fifo (parameterised width/depth, sync, FWFT).

Verification
REQ-033 Reset, RD_LAT=1: 16 reads all matching (exp=data=0x55) then end_in -> fail_out=0, fail_cnt_out=0, done_out=1, pass_out=1 two cycles after end_in.
REQ-034 Single fault: read addr 0x12 exp 0xAA, data 0xAB -> fail_out rises at t+2, fail_cnt_out=1, log entry {0x12, 0x01}.
REQ-035 RD_LAT=3, back-to-back reads, mismatches at addr 3 and 7 -> counts 1 then 2 at cycles t+4 of each, log order 3 then 7.
REQ-036 Log overflow: 10 mismatches, FIFO_DEPTH=8, no pops -> 8 entries kept (first eight), ovfl_out=1, fail_cnt_out=10; full-with-pop-and-push keeps 8.
REQ-037 clr_in asserted with two reads in flight -> all outputs 0 next cycle, those reads never counted.
REQ-038 300 mismatches -> fail_cnt_out holds 255; rebuild without RESPONSE_ANALYZER_FAIL_LOG_EN -> log outputs stay 0.
